// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA raster sequencer: position counters, sync/active decode, start/stop FSM
//
// Purpose:
//   Advances the horizontal/vertical raster position on every pixel tick and
//   registers hsync, vsync, video_on and the line/frame markers on the same
//   edge as the counters. A three-state FSM (IDLE/RUN/DRAIN) guarantees the
//   raster starts at (0,0) and stops only on a frame boundary.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   pixel_en     one-clk pixel tick
//   enable       level request to run the raster
//   hsync        horizontal sync, active-low
//   vsync        vertical sync, active-low
//   video_on     high inside the active window while busy
//   x, y         current horizontal / vertical count
//   line_start   one-clk pulse when x becomes 0 while running
//   frame_start  one-clk pulse when (x,y) becomes (0,0) while running
//   busy         high in RUN or DRAIN

module vga_timing_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_en,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;

  logic             x_end;
  logic             y_end;
  logic             frame_end_tick;
  logic [CNT_W-1:0] x_inc;
  logic [CNT_W-1:0] y_inc;

  // Wrap arithmetic for one pixel tick, shared by RUN and DRAIN.
  always_comb begin
    x_end          = (x_q == H_LAST);
    y_end          = (y_q == V_LAST);
    frame_end_tick = pixel_en & x_end & y_end;
    x_inc          = x_end ? CNT_ZERO : (x_q + CNT_ONE);
    if (x_end) begin
      y_inc = y_end ? CNT_ZERO : (y_q + CNT_ONE);
    end else begin
      y_inc = y_q;
    end
  end

  // Next-state, next-counter and pulse logic.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        x_d = CNT_ZERO;
        y_d = CNT_ZERO;
        // The first tick after enable is the tick that presents (0,0).
        if (enable && pixel_en) begin
          state_d       = ST_RUN;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (pixel_en) begin
          x_d           = x_inc;
          y_d           = y_inc;
          line_start_d  = x_end;
          frame_start_d = x_end & y_end;
        end
        if (enable) begin
          // Re-enabling while draining never disturbs the counters.
          state_d = ST_RUN;
        end else if (frame_end_tick) begin
          // Stop exactly at the frame boundary; no marker for a frame that
          // will not be drawn.
          state_d       = ST_IDLE;
          x_d           = CNT_ZERO;
          y_d           = CNT_ZERO;
          line_start_d  = 1'b0;
          frame_start_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        x_d     = CNT_ZERO;
        y_d     = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next-state counters so that sync/video line up
  // with x/y on the same edge.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    hsync_d    = ~(busy_d && (x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d    = ~(busy_d && (y_d >= VS_FIRST) && (y_d <= VS_LAST));
    video_on_d = busy_d && (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - directed bench for vga_timing_controller (small raster: 8 x 6 total)

module tb_vga_timing_controller;

  // H 4/1/2/1 -> H_TOTAL 8, hsync low x=5..6
  // V 3/1/1/1 -> V_TOTAL 6, vsync low y=4
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pixel_en = 1'b0;
  logic       enable = 1'b0;
  logic       hsync, vsync, video_on, line_start, frame_start, busy;
  logic [9:0] x, y;

  int checks = 0;
  int errors = 0;

  vga_timing_controller #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .enable(enable),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output snapshot: {x, y, hsync, vsync, video_on, line_start, frame_start, busy}
  function automatic logic [25:0] obs();
    return {x, y, hsync, vsync, video_on, line_start, frame_start, busy};
  endfunction

  // Called at a negedge; returns at the next negedge with the tick registered.
  task automatic tick();
    pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs(),
                 {10'd0, 10'd0, 6'b110000});
      end
      enable   = 1'($urandom_range(0, 1));
      pixel_en = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; pixel_en = 1'b0;
    @(negedge clk);
    tick();
    checks++;
    if (busy !== 1'b0 || frame_start !== 1'b0 || x !== 10'd0)
      begin errors++; $display("FAIL idle_no_enable busy=%b fs=%b x=%0d want 0/0/0", busy, frame_start, x); end
  endtask

  task automatic test_start();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_start !== 1'b0)
      begin errors++; $display("FAIL start_wait_tick busy=%b fs=%b want 0/0", busy, frame_start); end
    tick();
    checks++;
    if (obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1})
      begin errors++; $display("FAIL start_first_tick got=%h want=%h", obs(), {20'd0, 6'b111111}); end
    @(negedge clk);
    checks++;
    if (line_start !== 1'b0 || frame_start !== 1'b0)
      begin errors++; $display("FAIL start_pulse_width ls=%b fs=%b want 0/0", line_start, frame_start); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    int vo_ticks = 0;
    int fs_clks = 0;
    int ls_clks = 0;
    logic [9:0] ex, ey;
    logic [25:0] want;
    for (int k = 1; k <= 48; k++) begin
      tick();
      ex = 10'(k % 8);
      ey = 10'((k / 8) % 6);
      want = {ex, ey, !(ex >= 5 && ex <= 6), !(ey == 4), (ex < 4 && ey < 3),
              (ex == 0), (ex == 0 && ey == 0), 1'b1};
      checks++;
      if (obs() !== want)
        begin errors++; $display("FAIL frame_tick k=%0d got=%h want=%h", k, obs(), want); end
      if (video_on) vo_ticks++;
      if (frame_start) fs_clks++;
      if (line_start) ls_clks++;
      for (int g = 0; g < 3; g++) begin
        @(negedge clk);
        if (frame_start) fs_clks++;
        if (line_start) ls_clks++;
      end
    end
    checks++;
    if (vo_ticks !== 12) begin errors++; $display("FAIL frame_video_ticks got=%0d want=12", vo_ticks); end
    checks++;
    if (fs_clks !== 1) begin errors++; $display("FAIL frame_start_count got=%0d want=1", fs_clks); end
    checks++;
    if (ls_clks !== 6) begin errors++; $display("FAIL line_start_count got=%0d want=6", ls_clks); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ex, ey;
    pixel_en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      ex = 10'(k % 8);
      ey = 10'((k / 8) % 6);
      checks++;
      if (x !== ex || y !== ey || line_start !== (ex == 0) || frame_start !== (ex == 0 && ey == 0))
        begin
          errors++;
          $display("FAIL b2b k=%0d x=%0d y=%0d ls=%b fs=%b want x=%0d y=%0d", k, x, y,
                   line_start, frame_start, ex, ey);
        end
    end
    pixel_en = 1'b0;
  endtask

  task automatic test_stop_mid_frame();
    int fs_seen = 0;
    int idle_seen = 0;
    repeat (8) begin tick(); gap(); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || x !== 10'd0 || y !== 10'd1)
      begin errors++; $display("FAIL stop_enter_drain busy=%b x=%0d y=%0d want 1/0/1", busy, x, y); end
    for (int k = 0; k < 39; k++) begin
      tick();
      if (frame_start) fs_seen++;
      if (!busy) idle_seen++;
      gap();
    end
    checks++;
    if (fs_seen !== 0 || idle_seen !== 0 || x !== 10'd7 || y !== 10'd5)
      begin
        errors++;
        $display("FAIL stop_drain_run fs=%0d idle=%0d x=%0d y=%0d want 0/0/7/5", fs_seen, idle_seen, x, y);
      end
    tick();
    checks++;
    if (obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL stop_at_frame_end got=%h want=%h", obs(), {20'd0, 6'b110000}); end
    gap();
    tick();
    checks++;
    if (busy !== 1'b0 || x !== 10'd0 || frame_start !== 1'b0)
      begin errors++; $display("FAIL stop_stays_idle busy=%b x=%0d fs=%b want 0/0/0", busy, x, frame_start); end
    gap();
  endtask

  task automatic test_reenable_drain();
    int fs_seen = 0;
    enable = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL reen_restart fs=%b busy=%b want 1/1", frame_start, busy); end
    gap();
    repeat (24) begin tick(); gap(); end
    enable = 1'b0;
    repeat (2) begin tick(); gap(); end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 10'd2 || y !== 10'd3 || busy !== 1'b1)
      begin errors++; $display("FAIL reen_no_disturb x=%0d y=%0d busy=%b want 2/3/1", x, y, busy); end
    tick();
    checks++;
    if (x !== 10'd3 || y !== 10'd3)
      begin errors++; $display("FAIL reen_continuous x=%0d y=%0d want 3/3", x, y); end
    gap();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (frame_start) fs_seen++;
      gap();
    end
    tick();
    checks++;
    if (fs_seen !== 0 || frame_start !== 1'b1 || x !== 10'd0 || y !== 10'd0 || busy !== 1'b1)
      begin
        errors++;
        $display("FAIL reen_wrap early_fs=%0d fs=%b x=%0d y=%0d busy=%b want 0/1/0/0/1",
                 fs_seen, frame_start, x, y, busy);
      end
    gap();
  endtask

  task automatic test_stall();
    logic [25:0] held;
    int moved = 0;
    repeat (11) begin tick(); gap(); end
    checks++;
    if (x !== 10'd3 || y !== 10'd1 || video_on !== 1'b1)
      begin errors++; $display("FAIL stall_pos x=%0d y=%0d vo=%b want 3/1/1", x, y, video_on); end
    held = {x, y, hsync, vsync, video_on, 3'b001};
    repeat (50) begin
      @(negedge clk);
      if (obs() !== held) moved++;
    end
    checks++;
    if (moved !== 0) begin errors++; $display("FAIL stall_frozen changed_cycles=%0d want 0", moved); end
    tick();
    checks++;
    if (x !== 10'd4 || y !== 10'd1 || video_on !== 1'b0 || hsync !== 1'b1)
      begin errors++; $display("FAIL stall_resume x=%0d y=%0d vo=%b hs=%b want 4/1/0/1", x, y, video_on, hsync); end
    gap();
  endtask

  task automatic test_reset_mid_line();
    repeat (26) begin tick(); gap(); end
    checks++;
    if (x !== 10'd6 || y !== 10'd4 || hsync !== 1'b0 || vsync !== 1'b0)
      begin errors++; $display("FAIL rml_pos x=%0d y=%0d hs=%b vs=%b want 6/4/0/0", x, y, hsync, vsync); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL rml_async got=%h want=%h", obs(), {20'd0, 6'b110000}); end
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; pixel_en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rml_wait_tick busy=%b want 0", busy); end
    tick();
    checks++;
    if (obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1})
      begin errors++; $display("FAIL rml_restart got=%h want=%h", obs(), {20'd0, 6'b111111}); end
    gap();
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_frame();
    test_back_to_back();
    test_stop_mid_frame();
    test_reenable_drain();
    test_stall();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Sequences the VGA raster from the 25 MHz pixel enable produced by the frequency-divider block. It owns the horizontal/vertical position counters and generates hsync, vsync, the active-video window, and frame/line markers for the pixel datapath. A start/stop FSM guarantees the raster always starts at pixel (0,0) and stops only on a frame boundary.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- pixel_en  in  1  one-clk pixel tick (from frequency divider)
- enable  in  1  level request to run the raster
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high inside active window
- x  out  CNT_W  current horizontal count
- y  out  CNT_W  current vertical count
- line_start  out  1  one-clk pulse when x becomes 0 while running
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0) while running
- busy  out  1  high in RUN or DRAIN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: x=y=0 held, hsync=vsync=1, video_on=0. Go to RUN on the clk edge where enable=1 and pixel_en=1; frame_start and line_start pulse on that edge.
  - RUN: on each pixel_en, x increments; at x=H_TOTAL-1 x wraps to 0 and y increments; at y=V_TOTAL-1 and x=H_TOTAL-1, y wraps to 0. enable=0 moves to DRAIN (counting continues).
  - DRAIN: counting continues. enable=1 returns to RUN with no counter disturbance. At the frame-end tick (x=H_TOTAL-1, y=V_TOTAL-1, pixel_en=1): if enable=0, go to IDLE with x=y=0; otherwise wrap into RUN with frame_start.
- Decode (from next-state counters, registered on the same edge as x/y):
  - hsync=0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vsync=0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
  - video_on=1 iff busy, x<H_ACTIVE and y<V_ACTIVE.
- pixel_en=0: all outputs hold, except single-cycle pulses, which return to 0.
- Counter arithmetic is unsigned modulo the totals. x/y never exceed H_TOTAL-1 or V_TOTAL-1.

## Timing
- Reset (reset=0, asynchronous) values: state IDLE, x=0, y=0, hsync=1, vsync=1, video_on=0, line_start=0, frame_start=0, busy=0.
- Reset mid-frame forces the reset values immediately. After release, the FSM restarts from IDLE and needs a fresh enable∧pixel_en.
- All outputs are registered, with zero latency between x/y and hsync/vsync/video_on: they update on the same clk edge.
- Pulses are exactly one clk wide, coincident with the pixel_en edge that loads the new count.
- With pixel_en every 4th clk: a line is 3200 clks, a frame is 1,680,000 clks, hsync low for 384 clks, vsync low for 2 lines (6400 clks).
- enable is sampled only on clk edges. enable toggling between pixel ticks has no effect until the next relevant edge.

## Test plan
- Reset: hold reset=0 with random enable/pixel_en -> x=y=0, hsync=vsync=1, video_on=busy=0, no pulses.
- Full frame with default parameters, pixel_en 1-in-4, enable=1:
  - frame_start once every 1,680,000 clks; line_start every 3200 clks.
  - hsync low for x=656..751; vsync low for y=490..491.
  - video_on high for exactly 307,200 pixel ticks per frame.
- Stop mid-frame: drop enable at y=100 -> busy stays 1 until frame end, then x=y=0, busy=0, with no extra frame_start.
- Re-enable during DRAIN at y=300 -> counting is continuous, and frame_start fires at the next wrap.
- Stall: hold pixel_en=0 for 50 clks at x=639,y=10 -> outputs frozen. The next tick gives x=640 and video_on=0.
- Reset mid-line: assert reset at x=700,y=200 -> outputs take reset values immediately (asynchronously). After release with enable=1, the first tick yields frame_start and x=y=0. Also rerun with small parameters (H 4/1/2/1, V 3/1/1/1) to check wrap boundaries.
